// File: rtl/mul_approx_seq_if.sv
// Operand/result handshake bundle for mul_approx_seq.
interface mul_approx_seq_if #(
  parameter int WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] prod;
  logic               err_flag;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, prod, err_flag
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, prod, err_flag
  );
endinterface

// File: rtl/mul_approx_seq.sv
// Radix-2 shift-add multiplier computing exact and column-truncated products
// side by side, with an error flag and a saturating error-result counter.
module mul_approx_seq #(
  parameter int               WIDTH = 4,
  parameter int               TRUNC = 2,
  parameter logic [2*WIDTH-1:0] ET  = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  mul_approx_seq_if.slave     bus,
  input  logic                clr_cnt,
  output logic [7:0]          err_cnt
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [PW-1:0] ONE  = PW'(1);
  // Clears partial-product columns below TRUNC; all ones when TRUNC = 0.
  localparam logic [PW-1:0] MASK = ~((ONE << TRUNC) - ONE);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             mode_q;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    acc_ex;
  logic [PW-1:0]    acc_ap;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    prod_w;
  logic [PW-1:0]    diff;
  logic             err_w;
  logic             deliver;

  always_comb begin
    addend  = {{WIDTH{1'b0}}, a_q} << cnt;
    prod_w  = mode_q ? acc_ap : acc_ex;
    // The approximate sum drops only non-negative terms, so this never wraps.
    diff    = acc_ex - prod_w;
    err_w   = diff > ET;
    deliver = (state == DONE) && bus.out_ready;
  end

  assign bus.in_ready  = rst_n && (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.prod      = prod_w;
  assign bus.err_flag  = err_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      cnt    <= '0;
      acc_ex <= '0;
      acc_ap <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            mode_q <= bus.mode;
            cnt    <= '0;
            acc_ex <= '0;
            acc_ap <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (b_q[cnt]) begin
            acc_ex <= acc_ex + addend;
            acc_ap <= acc_ap + (addend & MASK);
          end
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt <= '0;
    end else if (deliver && err_w && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_mul_approx_seq.sv
// Randomized and directed checks of mul_approx_seq against a bit-matrix model.
module tb_mul_approx_seq;
  localparam int W   = 4;
  localparam int T   = 2;
  localparam int PW  = 2 * W;
  localparam logic [PW-1:0] ETV = '0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr_cnt;
  logic [7:0]    err_cnt;

  mul_approx_seq_if #(.WIDTH(W)) bus ();

  mul_approx_seq #(.WIDTH(W), .TRUNC(T), .ET(ETV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .clr_cnt (clr_cnt),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] exp_prod;
  logic          exp_err;
  int            model_cnt;
  logic [PW-1:0] last_prod;
  logic          last_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Sum of the partial-product matrix, skipping columns i+j < T in approximate mode.
  function automatic logic [PW-1:0] model_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic m);
    logic [PW-1:0] s;
    s = '0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (x[i] && y[j] && (!m || (i + j) >= T))
          s = s + (PW'(1) << (i + j));
    return s;
  endfunction

  function automatic logic model_err(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic m);
    int unsigned ex;
    ex = int'(x) * int'(y);
    return (ex - int'(model_prod(x, y, m))) > int'(ETV);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        chk("mon_prod", bus.prod, exp_prod);
        chk("mon_err", bus.err_flag, exp_err);
      end
      chk("mon_cnt", err_cnt, model_cnt);
    end
  end

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic m,
                    input int hold, input bit clr, input bit poke);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ready", bus.in_ready, 1);
    bus.a = x; bus.b = y; bus.mode = m; bus.in_valid = 1'b1;
    exp_prod = model_prod(x, y, m);
    exp_err  = model_err(x, y, m);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.mode = 1'($urandom);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.out_valid && n < 20);
    chk("latency", n, W);
    last_prod = bus.prod;
    last_err  = bus.err_flag;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (poke) begin
        bus.in_valid = 1'b1;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.mode = 1'($urandom);
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    clr_cnt = clr;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    clr_cnt = 1'b0;
    bus.in_valid = 1'b0;
    if (clr) model_cnt = 0;
    else if (exp_err && model_cnt < 255) model_cnt++;
    chk("handoff_ovalid", bus.out_valid, 0);
    chk("handoff_iready", bus.in_ready, 1);
    @(negedge clk);
    chk("no_handoff_accept", bus.in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; clr_cnt = 1'b0; model_cnt = 0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.mode = 1'b0; bus.out_ready = 1'b0;
    exp_prod = '0; exp_err = 1'b0;
    #2;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_prod", bus.prod, 0);
    chk("rst_err_flag", bus.err_flag, 0);
    chk("rst_err_cnt", err_cnt, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", bus.in_ready, 1);

    chk("pin_3x3", model_prod(4'd3, 4'd3, 1'b1), 4);
    chk("pin_15x15a", model_prod(4'd15, 4'd15, 1'b1), 220);
    chk("pin_15x15e", model_prod(4'd15, 4'd15, 1'b0), 225);
    chk("pin_4x4", model_prod(4'd4, 4'd4, 1'b1), 16);

    op(4'd3, 4'd3, 1'b1, 0, 1'b0, 1'b0);
    chk("d3x3_prod", last_prod, 4);
    chk("d3x3_err", last_err, 1);
    chk("d3x3_cnt", err_cnt, 1);
    op(4'd15, 4'd15, 1'b1, 0, 1'b0, 1'b0);
    chk("d15a_prod", last_prod, 220);
    chk("d15a_err", last_err, 1);
    op(4'd15, 4'd15, 1'b0, 0, 1'b0, 1'b0);
    chk("d15e_prod", last_prod, 225);
    chk("d15e_err", last_err, 0);
    op(4'd4, 4'd4, 1'b1, 0, 1'b0, 1'b0);
    chk("d4x4_prod", last_prod, 16);
    chk("d4x4_err", last_err, 0);
    chk("d4x4_cnt", err_cnt, 2);

    op(4'd7, 4'd9, 1'b1, 5, 1'b0, 1'b1);
    chk("stall_prod", last_prod, 60);

    for (int i = 0; i < 260; i++) op(4'd3, 4'd3, 1'b1, 0, 1'b0, 1'b0);
    chk("sat_cnt", err_cnt, 255);
    op(4'd3, 4'd3, 1'b1, 0, 1'b1, 1'b0);
    chk("clr_cnt", err_cnt, 0);

    @(negedge clk);
    bus.a = 4'd11; bus.b = 4'd13; bus.mode = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    model_cnt = 0;
    #1;
    chk("abort_in_ready", bus.in_ready, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_prod", bus.prod, 0);
    chk("abort_err_flag", bus.err_flag, 0);
    chk("abort_err_cnt", err_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    op(4'd11, 4'd13, 1'b1, 0, 1'b0, 1'b0);
    chk("after_abort_prod", last_prod, 140);
    chk("after_abort_cnt", err_cnt, 1);

    for (int i = 0; i < 60; i++)
      op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3),
         ($urandom_range(0, 7) == 0), 1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_approx_seq.md
MUL_APPROX_SEQ -- requirements
Module: mul_approx_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand width in bits; legal range 2..16.
REQ-002 SHALL have parameter TRUNC, default 2: in approximate mode, partial-product bits in columns i+j < TRUNC are dropped; legal range 0..2*WIDTH-1.
REQ-003 SHALL have parameter ET, default 0: error threshold, unsigned, 2*WIDTH bits.
REQ-004 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1: operand request.
REQ-007 SHALL have port in_ready, output, 1: block can accept operands.
REQ-008 SHALL have port a, input, WIDTH: multiplicand, unsigned.
REQ-009 SHALL have port b, input, WIDTH: multiplier, unsigned.
REQ-010 SHALL have port mode, input, 1: 1 = approximate, 0 = exact; sampled at accept.
REQ-011 SHALL have port out_valid, output, 1: result available.
REQ-012 SHALL have port out_ready, input, 1: consumer takes result.
REQ-013 SHALL have port prod, output, 2*WIDTH: result, exact or approximate per latched mode.
REQ-014 SHALL have port err_flag, output, 1: (exact - prod) > ET for the current result.
REQ-015 SHALL have port clr_cnt, input, 1: synchronous clear of err_cnt.
REQ-016 SHALL have port err_cnt, output, 8: saturating count of delivered results with err_flag = 1.

Function
REQ-017 SHALL implement the FSM states IDLE, BUSY and DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-018 SHALL accept operands on a rising edge where state = IDLE and in_valid = 1: latch a, b and mode; clear both accumulators and the bit counter; go to BUSY.
REQ-019 SHALL process one bit b[k] per BUSY cycle (radix-2 shift-add), k = 0..WIDTH-1; when b[k] = 1, add a<<k to the exact accumulator.
REQ-020 SHALL add to the approximate accumulator, on the same cycle, (a<<k) with bits below column TRUNC masked to 0.
REQ-021 SHALL move BUSY -> DONE on the edge that processes k = WIDTH-1; out_valid is therefore first high exactly WIDTH cycles after the accept edge.
REQ-022 SHALL hold prod, err_flag and out_valid stable in DONE while out_ready = 0.
REQ-023 SHALL, on an edge in DONE with out_ready = 1, go to IDLE; in_ready rises the following cycle, and there is no accept in the handoff cycle.
REQ-024 SHALL drive prod = approximate accumulator when latched mode = 1, else the exact accumulator; err_flag = (exact - prod) > ET; exact - prod is never negative.
REQ-025 SHALL force err_flag = 0 and prod equal to the exact product when mode = 0 or TRUNC = 0.
REQ-026 SHALL increment err_cnt on the delivery edge (DONE and out_ready) when err_flag = 1, and saturate at 255.
REQ-027 SHALL give clr_cnt priority over an increment in the same cycle; err_cnt becomes 0.
REQ-028 SHALL ignore in_valid, a, b and mode while in BUSY or DONE.
REQ-029 SHALL use no intermediate truncation: both accumulators are 2*WIDTH bits wide and cannot overflow.

Reset
REQ-030 SHALL, while rst_n = 0 and regardless of clk: state = IDLE; in_ready = 0 during reset, then 1 in IDLE after release; out_valid = 0, prod = 0, err_flag = 0, err_cnt = 0, counter = 0.
REQ-031 SHALL abort any operation in progress when reset is asserted mid-BUSY or mid-DONE, with no result delivered and err_cnt unchanged from 0.

Verification (WIDTH=4, TRUNC=2, ET=0)
REQ-032 SHALL cover: a=3, b=3, mode=1 -> out_valid 4 cycles after accept; prod=4; err_flag=1; err_cnt=1 after out_ready.
REQ-033 SHALL cover: a=15, b=15, mode=1 -> prod=220, err_flag=1; the same operands with mode=0 -> prod=225, err_flag=0.
REQ-034 SHALL cover: a=4, b=4, mode=1 -> prod=16, err_flag=0, err_cnt unchanged.
REQ-035 SHALL cover: out_ready held 0 for 5 cycles in DONE -> prod and out_valid stable; a new in_valid pulse during that time is ignored.
REQ-036 SHALL cover: 260 erroring results -> err_cnt=255; clr_cnt asserted together with a delivery -> err_cnt=0.
REQ-037 SHALL cover: rst_n dropped 2 cycles into BUSY -> all outputs at their reset values immediately; the next operation after release is correct.
